l2k_tlb_refill_ctrl: RTL and testbench

// Hardware TLB refill sequencer for the Limn2600 MMU. Arbitrates translation-miss requests from the

---
 rtl/l2k_pkg.sv | 39 +++
 rtl/l2k_rr_arb2.sv | 33 +++
 rtl/l2k_tlb_refill_ctrl.sv | 179 +++++++++++++++++
 tb/tb_l2k_tlb_refill_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2k_pkg.sv
// Shared constants and types for the Limn2600 TLB refill path:
// walk states, fault codes and the packed TLB entry layout.
package l2k_pkg;

   localparam int L2K_TLB_IDX_W = 6;
   localparam int L2K_ASID_W    = 12;
   localparam int L2K_TIMEOUT   = 255;

   // PTE bit positions; the entry carries the PTE unmodified
   localparam int PTE_V  = 0;
   localparam int PTE_W  = 1;
   localparam int PTE_K  = 2;
   localparam int PTE_NC = 3;
   localparam int PTE_G  = 4;

   typedef enum logic [1:0] {
      FLT_NONE = 2'b00,
      FLT_PDE  = 2'b01,
      FLT_PTE  = 2'b10,
      FLT_BUS  = 2'b11
   } fault_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_L1_REQ  = 3'd1,
      ST_L1_WAIT = 3'd2,
      ST_L2_REQ  = 3'd3,
      ST_L2_WAIT = 3'd4,
      ST_FILL    = 3'd5,
      ST_DONE    = 3'd6
   } walk_state_t;

   typedef struct packed {
      logic [19:0]           vpn;
      logic [L2K_ASID_W-1:0] asid;
      logic [31:0]           pte;
   } tlb_entry_t;

endpackage

// File: rtl/l2k_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins outright, a tie goes to
// the port that was not granted last. Pointer moves only on an actual grant.
module l2k_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_req,
   input  logic       i_en,
   output logic       o_gnt_valid,
   output logic       o_gnt_port
);

   logic r_last;

   always_comb begin
      o_gnt_valid = i_en && (i_req != 2'b00);
      o_gnt_port  = 1'b0;
      case (i_req)
         2'b01:   o_gnt_port = 1'b0;
         2'b10:   o_gnt_port = 1'b1;
         2'b11:   o_gnt_port = ~r_last;
         default: o_gnt_port = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= 1'b0;
      end else if (o_gnt_valid) begin
         r_last <= o_gnt_port;
      end
   end

endmodule

// File: rtl/l2k_tlb_refill_ctrl.sv
// Hardware TLB refill sequencer: arbitrates I/D miss ports, walks the
// two-level page table over the bus and writes the resulting TLB entry.
module l2k_tlb_refill_ctrl
   import l2k_pkg::*;
#(
   parameter int TLB_IDX_W = L2K_TLB_IDX_W,
   parameter int TIMEOUT   = L2K_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [19:0]           ptb,
   input  logic [L2K_ASID_W-1:0] asid,
   input  logic [1:0]            req_valid,
   input  logic [63:0]           req_vaddr,
   output logic [1:0]            req_done,
   output logic [1:0]            req_fault,
   output logic                  mem_req,
   output logic [31:0]           mem_addr,
   input  logic                  mem_ack,
   input  logic [31:0]           mem_rdata,
   output logic                  tlb_we,
   output logic [TLB_IDX_W-1:0]  tlb_index,
   output logic [63:0]           tlb_entry,
   output logic                  busy
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   walk_state_t           r_state, w_state_next;
   logic                  r_port, w_port_next;
   logic [19:0]           r_vpn, w_vpn_next;
   logic [L2K_ASID_W-1:0] r_asid, w_asid_next;
   logic [19:0]           r_ptb, w_ptb_next;
   logic [19:0]           r_pde_frame, w_pde_next;
   logic [31:0]           r_pte, w_pte_next;
   fault_t                r_fault, w_fault_next;
   logic [7:0]            r_tmo, w_tmo_next;

   logic                  w_gnt_valid;
   logic                  w_gnt_port;
   logic [31:0]           w_gnt_va;
   tlb_entry_t            w_entry;
   logic                  w_unused_va;

   l2k_rr_arb2 u_arb (
      .clk         (clk),
      .rst         (rst),
      .i_req       (req_valid),
      .i_en        (r_state == ST_IDLE),
      .o_gnt_valid (w_gnt_valid),
      .o_gnt_port  (w_gnt_port)
   );

   assign w_gnt_va    = w_gnt_port ? req_vaddr[63:32] : req_vaddr[31:0];
   // page offset bits play no part in a walk
   assign w_unused_va = ^{req_vaddr[43:32], req_vaddr[11:0]};
   assign w_entry     = '{vpn: r_vpn, asid: r_asid, pte: r_pte};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_port      <= 1'b0;
         r_vpn       <= '0;
         r_asid      <= '0;
         r_ptb       <= '0;
         r_pde_frame <= '0;
         r_pte       <= '0;
         r_fault     <= FLT_NONE;
         r_tmo       <= '0;
      end else begin
         r_state     <= w_state_next;
         r_port      <= w_port_next;
         r_vpn       <= w_vpn_next;
         r_asid      <= w_asid_next;
         r_ptb       <= w_ptb_next;
         r_pde_frame <= w_pde_next;
         r_pte       <= w_pte_next;
         r_fault     <= w_fault_next;
         r_tmo       <= w_tmo_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_port_next  = r_port;
      w_vpn_next   = r_vpn;
      w_asid_next  = r_asid;
      w_ptb_next   = r_ptb;
      w_pde_next   = r_pde_frame;
      w_pte_next   = r_pte;
      w_fault_next = r_fault;
      w_tmo_next   = r_tmo;

      req_done  = '0;
      req_fault = '0;
      mem_req   = 1'b0;
      mem_addr  = '0;
      tlb_we    = 1'b0;
      tlb_index = '0;
      tlb_entry = '0;
      busy      = (r_state != ST_IDLE);

      case (r_state)
         ST_IDLE: begin
            if (w_gnt_valid) begin
               w_state_next = ST_L1_REQ;
               w_port_next  = w_gnt_port;
               w_vpn_next   = w_gnt_va[31:12];
               w_asid_next  = asid;
               w_ptb_next   = ptb;
               w_fault_next = FLT_NONE;
            end
         end
         ST_L1_REQ: begin
            mem_req      = 1'b1;
            mem_addr     = {r_ptb, r_vpn[19:10], 2'b00};
            w_tmo_next   = '0;
            w_state_next = ST_L1_WAIT;
         end
         ST_L1_WAIT: begin
            mem_req  = 1'b1;
            mem_addr = {r_ptb, r_vpn[19:10], 2'b00};
            if (mem_ack) begin
               w_pde_next = mem_rdata[31:12];
               if (!mem_rdata[PTE_V]) begin
                  w_fault_next = FLT_PDE;
                  w_state_next = ST_DONE;
               end else begin
                  w_state_next = ST_L2_REQ;
               end
            end else if (r_tmo == TMO_LAST) begin
               w_fault_next = FLT_BUS;
               w_state_next = ST_DONE;
            end else begin
               w_tmo_next = r_tmo + 8'd1;
            end
         end
         ST_L2_REQ: begin
            mem_req      = 1'b1;
            mem_addr     = {r_pde_frame, r_vpn[9:0], 2'b00};
            w_tmo_next   = '0;
            w_state_next = ST_L2_WAIT;
         end
         ST_L2_WAIT: begin
            mem_req  = 1'b1;
            mem_addr = {r_pde_frame, r_vpn[9:0], 2'b00};
            if (mem_ack) begin
               w_pte_next = mem_rdata;
               if (!mem_rdata[PTE_V]) begin
                  w_fault_next = FLT_PTE;
                  w_state_next = ST_DONE;
               end else begin
                  w_state_next = ST_FILL;
               end
            end else if (r_tmo == TMO_LAST) begin
               w_fault_next = FLT_BUS;
               w_state_next = ST_DONE;
            end else begin
               w_tmo_next = r_tmo + 8'd1;
            end
         end
         ST_FILL: begin
            tlb_we       = 1'b1;
            tlb_index    = r_vpn[TLB_IDX_W-1:0];
            tlb_entry    = w_entry;
            w_state_next = ST_DONE;
         end
         ST_DONE: begin
            req_done[r_port] = 1'b1;
            req_fault        = r_fault;
            w_state_next     = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_l2k_tlb_refill_ctrl.sv
// Self-checking bench for l2k_tlb_refill_ctrl: randomized walks against a
// transaction-level page-table model with a delay-programmable bus responder.
module tb_l2k_tlb_refill_ctrl;
   import l2k_pkg::*;

   localparam int TMO = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic [19:0] ptb;
   logic [11:0] asid;
   logic [1:0]  req_valid;
   logic [63:0] req_vaddr;
   logic [1:0]  req_done;
   logic [1:0]  req_fault;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        tlb_we;
   logic [5:0]  tlb_index;
   logic [63:0] tlb_entry;
   logic        busy;

   l2k_tlb_refill_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .ptb       (ptb),
      .asid      (asid),
      .req_valid (req_valid),
      .req_vaddr (req_vaddr),
      .req_done  (req_done),
      .req_fault (req_fault),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .tlb_we    (tlb_we),
      .tlb_index (tlb_index),
      .tlb_entry (tlb_entry),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- bus responder: ack after a queued number of WAIT cycles
   bit [31:0]   mem [bit [31:0]];
   int          dly_q[$];
   bit          pend = 1'b0;
   int          bcnt = 0;
   int          bdly = 0;
   logic [31:0] baddr = 32'h0;
   int          n_reads = 0;
   int          stray_cnt = 0;
   int          stray_seen = 0;

   always @(negedge clk) begin
      if (rst) begin
         pend    = 1'b0;
         mem_ack = 1'b0;
      end else begin
         if (mem_ack) begin
            mem_ack = 1'b0;
            pend    = 1'b0;
         end
         if (stray_cnt != stray_seen) begin
            stray_seen = stray_cnt;
            mem_ack    = 1'b1;
            mem_rdata  = 32'hFFFF_FFFF;
         end else if (pend && !mem_req) begin
            pend = 1'b0;
         end else if (pend) begin
            check("mem_addr_hold", mem_addr, baddr);
            if (bcnt == bdly) begin
               mem_ack   = 1'b1;
               mem_rdata = mem.exists(baddr) ? mem[baddr] : 32'h0;
            end else begin
               bcnt++;
            end
         end else if (mem_req) begin
            pend  = 1'b1;
            bcnt  = 0;
            baddr = mem_addr;
            bdly  = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
            n_reads++;
         end
      end
   end

   // ---------------- output monitor
   logic [69:0] tlbw_q[$];
   int          mon_done = 0;
   always @(negedge clk) begin
      if (!rst) begin
         if (tlb_we) tlbw_q.push_back({tlb_index, tlb_entry});
         if (req_done != 2'b00) mon_done++;
      end
   end

   // ---------------- walk plan (indexed by port) and reference model
   logic [31:0] pl_va[2];
   logic [31:0] pl_pde[2];
   logic [31:0] pl_pte[2];
   logic [11:0] pl_asid[2];
   int          pl_d1[2];
   int          pl_d2[2];
   bit          last_gnt = 1'b0;

   function automatic int pick_delay(input int tmo_pct);
      int r;
      r = $urandom_range(0, 99);
      if (r < tmo_pct) return TMO;
      if (r < 30) return $urandom_range(2, 9);
      return $urandom_range(0, 1);
   endfunction

   task automatic plan_random(input int tmo_pct);
      pl_va[0]     = $urandom;
      pl_va[1]     = $urandom;
      pl_va[1][22] = ~pl_va[0][22];
      for (int q = 0; q < 2; q++) begin
         pl_pde[q]  = {12'h020, 8'(q + 1 + 8 * $urandom_range(0, 15)), 11'($urandom),
                       ($urandom_range(0, 7) != 0)};
         pl_pte[q]  = $urandom;
         pl_pte[q][PTE_V] = ($urandom_range(0, 5) != 0);
         pl_asid[q] = 12'($urandom);
         pl_d1[q]   = pick_delay(tmo_pct);
         pl_d2[q]   = pick_delay(tmo_pct);
      end
   endtask

   task automatic execute(input logic [1:0] pat);
      int          order[2];
      int          efault[2];
      int          elat[2];
      logic [69:0] ew[$];
      logic [69:0] got_w;
      logic [69:0] exp_w;
      int          nw, p, gp, g, ndone, budget, reads0, done0, tw0, exp_reads;

      mem.delete();
      dly_q.delete();
      for (int q = 0; q < 2; q++) begin
         if (pat[q]) begin
            mem[{ptb, pl_va[q][31:22], 2'b00}]          = pl_pde[q];
            mem[{pl_pde[q][31:12], pl_va[q][21:12], 2'b00}] = pl_pte[q];
         end
      end

      if (pat == 2'b11) begin
         order[0] = last_gnt ? 0 : 1;
         order[1] = 1 - order[0];
         nw = 2;
      end else begin
         order[0] = pat[1] ? 1 : 0;
         order[1] = 0;
         nw = 1;
      end
      last_gnt = (order[nw-1] == 1);

      // walk outcome and grant-to-done latency from the state sequence
      for (int i = 0; i < nw; i++) begin
         p = order[i];
         dly_q.push_back(pl_d1[p]);
         if (pl_d1[p] >= TMO) begin
            efault[i] = 3; elat[i] = 3 + TMO - 1;
         end else if (!pl_pde[p][PTE_V]) begin
            efault[i] = 1; elat[i] = 3 + pl_d1[p];
         end else begin
            dly_q.push_back(pl_d2[p]);
            if (pl_d2[p] >= TMO) begin
               efault[i] = 3; elat[i] = 5 + pl_d1[p] + TMO - 1;
            end else if (!pl_pte[p][PTE_V]) begin
               efault[i] = 2; elat[i] = 5 + pl_d1[p] + pl_d2[p];
            end else begin
               efault[i] = 0; elat[i] = 6 + pl_d1[p] + pl_d2[p];
               ew.push_back({pl_va[p][17:12], pl_va[p][31:12], pl_asid[p], pl_pte[p]});
            end
         end
      end
      exp_reads = dly_q.size();

      reads0 = n_reads;
      done0  = mon_done;
      tw0    = tlbw_q.size();
      @(negedge clk);
      req_vaddr = {pl_va[1], pl_va[0]};
      req_valid = pat;
      asid      = pl_asid[order[0]];
      g         = cyc;
      ndone     = 0;
      budget    = 3000;
      while (ndone < nw && budget > 0) begin
         @(negedge clk);
         budget--;
         if (req_done != 2'b00) begin
            p  = order[ndone];
            gp = int'(req_done) - 1;
            $display("[TB] walk port=%0d va=%08h fault=%0d lat=%0d pte=%08h W=%0d K=%0d NC=%0d G=%0d",
                     gp, pl_va[p], req_fault, cyc - g, pl_pte[p], pl_pte[p][PTE_W],
                     pl_pte[p][PTE_K], pl_pte[p][PTE_NC], pl_pte[p][PTE_G]);
            check("done_port", gp, p);
            check("fault", req_fault, efault[ndone]);
            check("latency", cyc - g, elat[ndone]);
            check("mem_req_at_done", mem_req, 0);
            req_valid = req_valid & ~req_done;
            g = cyc + 1;
            ndone++;
            if (ndone < nw) asid = pl_asid[order[ndone]];
         end else if (busy) begin
            asid = 12'($urandom);
         end
      end
      if (budget == 0) check("walk_budget", ndone, nw);

      req_valid = 2'b00;
      repeat (2) @(negedge clk);
      check("busy_idle", busy, 0);
      check("reads", n_reads - reads0, exp_reads);
      check("done_count", mon_done - done0, nw);
      check("tlb_we_count", tlbw_q.size() - tw0, ew.size());
      for (int i = 0; i < ew.size() && (tw0 + i) < tlbw_q.size(); i++) begin
         got_w = tlbw_q[tw0 + i];
         exp_w = ew[i];
         check("tlb_index", got_w[69:64], exp_w[69:64]);
         check("tlb_entry", got_w[63:0], exp_w[63:0]);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_done"},   req_done, 0);
      check({tag, "_fault"},  req_fault, 0);
      check({tag, "_memreq"}, mem_req, 0);
      check({tag, "_addr"},   mem_addr, 0);
      check({tag, "_we"},     tlb_we, 0);
      check({tag, "_idx"},    tlb_index, 0);
      check({tag, "_entry"},  tlb_entry, 0);
      check({tag, "_busy"},   busy, 0);
   endtask

   task automatic set_port0(input logic [31:0] va, input logic [31:0] pde, input logic [31:0] pte,
                            input int d1, input int d2);
      pl_va[0] = va; pl_pde[0] = pde; pl_pte[0] = pte;
      pl_asid[0] = 12'($urandom); pl_d1[0] = d1; pl_d2[0] = d2;
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int done0, tw0;
      rst = 1'b1; req_valid = '0; req_vaddr = '0; asid = '0; ptb = 20'h00010;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;

      // directed walk with known table contents
      set_port0(32'h0040_3000, 32'h0002_0001, 32'h0055_5003, 0, 0);
      pl_asid[0] = 12'h5A5;
      execute(2'b01);
      // invalid PDE: one read, no fill
      set_port0(32'h0040_3000, 32'h0002_0000, 32'h0055_5003, 1, 0);
      execute(2'b01);
      // zero-wait back-to-back walks
      set_port0(32'h1234_5000, 32'h0003_0001, 32'h0077_7011, 0, 0);
      execute(2'b01);
      set_port0(32'h1234_6000, 32'h0003_0001, 32'h0077_8001, 0, 0);
      execute(2'b01);
      // ack on the last allowed wait cycle, then timeouts at L1 and L2
      set_port0(32'h0080_1000, 32'h0004_0001, 32'h0011_1001, TMO - 1, 2);
      execute(2'b01);
      set_port0(32'h0080_1000, 32'h0004_0001, 32'h0011_1001, TMO, 0);
      execute(2'b01);
      set_port0(32'h0080_2000, 32'h0004_0001, 32'h0011_2001, 0, TMO);
      execute(2'b01);
      // a stray ack after the timeout must be ignored
      done0 = mon_done; tw0 = tlbw_q.size();
      stray_cnt++;
      repeat (4) @(negedge clk);
      check("stray_busy", busy, 0);
      check("stray_done", mon_done - done0, 0);
      check("stray_we", tlbw_q.size() - tw0, 0);

      // reset in the middle of L1_WAIT abandons the walk
      set_port0(32'h0040_3000, 32'h0002_0001, 32'h0055_5003, 50, 0);
      mem.delete(); dly_q.delete(); dly_q.push_back(50);
      done0 = mon_done; tw0 = tlbw_q.size();
      @(negedge clk);
      req_vaddr = {32'h0, pl_va[0]}; req_valid = 2'b01;
      repeat (3) @(negedge clk);
      check("mid_walk_busy", busy, 1);
      check("mid_walk_memreq", mem_req, 1);
      rst = 1'b1; req_valid = 2'b00;
      @(negedge clk);
      check_outputs_zero("midreset");
      rst = 1'b0; last_gnt = 1'b0; dly_q.delete();
      repeat (3) @(negedge clk);
      check("rst_no_done", mon_done - done0, 0);
      check("rst_no_we", tlbw_q.size() - tw0, 0);

      // both ports after reset: port1 first, then port0
      plan_random(0);
      pl_pde[0][PTE_V] = 1'b1; pl_pde[1][PTE_V] = 1'b1;
      execute(2'b11);

      // randomized mix
      for (int it = 0; it < 40; it++) begin
         ptb = {8'h01, 12'($urandom)};
         plan_random(3);
         execute(2'($urandom_range(1, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
